// File: rtl/sbox_ddt_row_scanner.sv
// Captures a 6-bit S-box into a local table, then builds one DDT row for a
// requested input difference and reports its maximum and lowest argmax.
module sbox_ddt_row_scanner #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reload,
    input  logic [WIDTH-1:0] delta,
    output logic [WIDTH-1:0] sbox_x,
    input  logic [WIDTH-1:0] sbox_y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] max_count,
    output logic [WIDTH-1:0] max_beta,
    output logic             table_valid
);

    localparam int N = 1 << WIDTH;
    localparam logic [WIDTH-1:0] LAST_IDX = '1;

    if (WIDTH != 6) begin : g_width_check
        $error("sbox_ddt_row_scanner: only WIDTH=6 is supported");
    end
    if (CNT_W < 7) begin : g_cnt_check
        $error("sbox_ddt_row_scanner: CNT_W must hold the value 64");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_SCAN,
        S_FIND,
        S_DONE
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] idx_r;
    logic [WIDTH-1:0] delta_r;
    logic [CNT_W-1:0] run_max_r;
    logic [WIDTH-1:0] run_beta_r;

    logic [WIDTH-1:0] tbl  [N];
    logic [CNT_W-1:0] hist [N];

    logic [WIDTH-1:0] scan_beta_s;
    logic             find_hit_s;
    logic [CNT_W-1:0] find_max_s;
    logic [WIDTH-1:0] find_beta_s;

    assign sbox_x = (state_r == S_LOAD) ? idx_r : '0;

    // Strict greater-than keeps the lowest beta on ties.
    always_comb begin
        scan_beta_s = tbl[idx_r] ^ tbl[idx_r ^ delta_r];
        find_hit_s  = (hist[idx_r] > run_max_r);
        if (find_hit_s) begin
            find_max_s  = hist[idx_r];
            find_beta_s = idx_r;
        end else begin
            find_max_s  = run_max_r;
            find_beta_s = run_beta_r;
        end
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            idx_r       <= '0;
            delta_r     <= '0;
            run_max_r   <= '0;
            run_beta_r  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            max_count   <= '0;
            max_beta    <= '0;
            table_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        delta_r <= delta;
                        busy    <= 1'b1;
                        idx_r   <= '0;
                        if (!reload && table_valid) begin
                            state_r <= S_CLEAR;
                        end else begin
                            state_r <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    idx_r <= idx_r + 1'b1;
                    if (idx_r == LAST_IDX) begin
                        table_valid <= 1'b1;
                        state_r     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    idx_r      <= '0;
                    run_max_r  <= '0;
                    run_beta_r <= '0;
                    state_r    <= S_SCAN;
                end
                S_SCAN: begin
                    idx_r <= idx_r + 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_r <= S_FIND;
                    end
                end
                S_FIND: begin
                    idx_r      <= idx_r + 1'b1;
                    run_max_r  <= find_max_s;
                    run_beta_r <= find_beta_s;
                    if (idx_r == LAST_IDX) begin
                        max_count <= find_max_s;
                        max_beta  <= find_beta_s;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Table capture and histogram storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (state_r)
                S_LOAD: begin
                    tbl[idx_r] <= sbox_y;
                end
                S_CLEAR: begin
                    for (int b = 0; b < N; b++) begin
                        hist[b] <= '0;
                    end
                end
                S_SCAN: begin
                    hist[scan_beta_s] <= hist[scan_beta_s] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_ddt_row_scanner.sv
// Randomized self-checking bench for sbox_ddt_row_scanner; the S-box is modelled
// here as a lookup table and DDT rows are recomputed directly from it.
module tb_sbox_ddt_row_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       reload;
    logic [5:0] delta;
    logic [5:0] sbox_x;
    logic [5:0] sbox_y;
    logic       busy;
    logic       done;
    logic [6:0] max_count;
    logic [5:0] max_beta;
    logic       table_valid;

    int checks = 0;
    int errors = 0;

    logic [5:0] cur_tbl [64];

    always #5 clk = ~clk;

    sbox_ddt_row_scanner #(.WIDTH(6), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .reload(reload), .delta(delta),
        .sbox_x(sbox_x), .sbox_y(sbox_y), .busy(busy), .done(done),
        .max_count(max_count), .max_beta(max_beta), .table_valid(table_valid)
    );

    always_comb sbox_y = cur_tbl[sbox_x];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // GF(2^6) multiply modulo x^6 + x + 1
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p = 6'd0;
        logic [5:0] aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[5] ? ({aa[4:0], 1'b0} ^ 6'h03) : {aa[4:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [5:0] pow20(input logic [5:0] x);
        logic [5:0] r = 6'd1;
        for (int i = 0; i < 20; i++) r = gf_mul(r, x);
        return r;
    endfunction

    // mode 0 identity, 1 constant 0x2A, 2 x^20, 3 random
    task automatic set_sbox(input int m);
        for (int x = 0; x < 64; x++) begin
            case (m)
                0: cur_tbl[x] = 6'(x);
                1: cur_tbl[x] = 6'h2A;
                2: cur_tbl[x] = pow20(6'(x));
                default: cur_tbl[x] = 6'($urandom_range(0, 63));
            endcase
        end
    endtask

    task automatic ref_row(input int d, output int mx, output int mb);
        int h[64];
        for (int b = 0; b < 64; b++) h[b] = 0;
        for (int x = 0; x < 64; x++) h[cur_tbl[x] ^ cur_tbl[x ^ d]]++;
        mx = 0;
        mb = 0;
        for (int b = 0; b < 64; b++) begin
            if (h[b] > mx) begin
                mx = h[b];
                mb = b;
            end
        end
    endtask

    // Issues one request and waits for done; lat counts the cycle after the accepting edge as 1.
    task automatic run(input int d, input bit rl, input int exp_lat, input bit inject,
                       output bit x_moved);
        int lat;
        int extra;
        @(posedge clk); #1;
        start = 1'b1; delta = 6'(d); reload = rl;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        x_moved = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        while (!done && lat < 400) begin
            if (sbox_x != 6'd0) x_moved = 1'b1;
            if (inject && lat == 100) begin
                start = 1'b1; delta = ~6'(d); reload = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("busy_at_done", int'(busy), 0);
        if (inject) begin
            start = 1'b1; delta = ~6'(d); reload = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            extra = 0;
            for (int c = 0; c < 250; c++) begin
                if (done || busy) extra++;
                @(posedge clk); #1;
            end
            check("ignored_start_extra_activity", extra, 0);
        end
    endtask

    initial begin
        bit mv;
        int mx, mb, d;
        int order[63];

        rst = 1'b1; start = 1'b0; reload = 1'b0; delta = 6'd0;
        set_sbox(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_max_count", int'(max_count), 0);
        check("rst_max_beta", int'(max_beta), 0);
        check("rst_table_valid", int'(table_valid), 0);
        check("rst_sbox_x", int'(sbox_x), 0);
        rst = 1'b0;

        // Abort during LOAD cycle 30
        @(posedge clk); #1;
        start = 1'b1; delta = 6'h05; reload = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) begin
            @(posedge clk); #1;
        end
        check("midload_sbox_x_active", int'(sbox_x), 29);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_table_valid", int'(table_valid), 0);
        check("abort_sbox_x", int'(sbox_x), 0);

        // reload=0 must still load since the table is invalid
        run(6'h05, 1'b0, 194, 1'b0, mv);
        check("id_d5_max_count", int'(max_count), 64);
        check("id_d5_max_beta", int'(max_beta), 5);
        check("id_d5_table_valid", int'(table_valid), 1);

        run(6'h00, 1'b0, 130, 1'b0, mv);
        check("id_d0_max_count", int'(max_count), 64);
        check("id_d0_max_beta", int'(max_beta), 0);
        check("skip_sbox_x_quiet", int'(mv), 0);

        set_sbox(1);
        run(6'h3F, 1'b1, 194, 1'b0, mv);
        check("const_max_count", int'(max_count), 64);
        check("const_max_beta", int'(max_beta), 0);

        // x^20 with start pulses during SCAN and in the done cycle
        set_sbox(2);
        d = $urandom_range(1, 63);
        ref_row(d, mx, mb);
        run(d, 1'b1, 194, 1'b1, mv);
        check("inject_max_count", int'(max_count), mx);
        check("inject_max_beta", int'(max_beta), mb);

        // Full nonzero-delta sweep in shuffled order
        for (int i = 0; i < 63; i++) order[i] = i + 1;
        for (int i = 62; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 63; i++) begin
            ref_row(order[i], mx, mb);
            run(order[i], (i == 0), (i == 0) ? 194 : 130, 1'b0, mv);
            check("sweep_max_count", int'(max_count), mx);
            check("sweep_max_beta", int'(max_beta), mb);
            check("sweep_even", int'(max_count[0]), 0);
        end

        // Random tables, one reload followed by skipped runs
        for (int k = 0; k < 4; k++) begin
            set_sbox(3);
            for (int r = 0; r < 3; r++) begin
                d = $urandom_range(0, 63);
                ref_row(d, mx, mb);
                run(d, (r == 0), (r == 0) ? 194 : 130, 1'b0, mv);
                check("rand_max_count", int'(max_count), mx);
                check("rand_max_beta", int'(max_beta), mb);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
